// File: rtl/mips_mon_pkg.sv
// Shared types and helpers for the MIPS run monitor: opcode constants,
// monitor FSM state encoding and jump-target formation.
package mips_mon_pkg;

  localparam logic [5:0] OP_J = 6'b000010;

  typedef enum logic [1:0] {
    S_RUN,
    S_CHECK,
    S_DONE
  } mon_state_e;

  // Absolute target of a J-type instruction fetched at pc.
  function automatic logic [31:0] j_target(input logic [31:0] pc,
                                           input logic [31:0] instr);
    return {pc[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mips_halt_detect.sv
// Recognises a core parked on a jump-to-self. Pulses halt_o in the cycle where
// the run of consecutive jump-to-self fetches first reaches HALT_STABLE.
module mips_halt_detect
  import mips_mon_pkg::*;
#(
  parameter int HALT_STABLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        halt_o
);

  localparam int SW = $clog2(HALT_STABLE + 1);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          match;

  // NOTE: every signal gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    match    = (instr_i[31:26] == OP_J) && (j_target(pc_i, instr_i) == pc_i);
    streak_d = '0;
    if (match) begin
      streak_d = (streak_q == SW'(HALT_STABLE)) ? streak_q : streak_q + SW'(1);
    end
  end

  // Fires only on the transition into the full streak; saturation keeps it a pulse.
  assign halt_o = match && (streak_q == SW'(HALT_STABLE - 1));

  // NOTE: clocked state uses non-blocking assignment so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for the single-cycle MIPS core: shadows selected registers while
// the program runs, then checks them one slot per cycle after halt or timeout.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NCHK        = 4,
  parameter int TIMEOUT_CYC = 20,
  parameter int HALT_STABLE = 2,
  localparam int CW         = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [31:0]          instr_i,
  input  logic                 rf_we_i,
  input  logic [4:0]           rf_waddr_i,
  input  logic [XLEN-1:0]      rf_wdata_i,
  input  logic [NCHK*5-1:0]    chk_idx_i,
  input  logic [NCHK*XLEN-1:0] chk_val_i,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [NCHK-1:0]      fail_mask_o,
  output logic [CW-1:0]        cycle_cnt_o
);

  localparam int KW = (NCHK > 1) ? $clog2(NCHK) : 1;

  mon_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [KW-1:0]         chk_k_q;
  logic                  done_q;
  logic                  pass_q;
  logic                  timeout_q;
  logic [NCHK-1:0]       fail_mask_q;
  logic [XLEN-1:0]       shadow_q [NCHK];

  logic [4:0]            chk_idx [NCHK];
  logic [XLEN-1:0]       chk_val [NCHK];
  logic                  halt;
  logic                  slot_fail;
  logic [NCHK-1:0]       fail_mask_d;

  mips_halt_detect #(
    .HALT_STABLE (HALT_STABLE)
  ) u_halt_detect (
    .clk     (clk),
    .reset   (reset),
    .pc_i    (pc_i[31:0]),
    .instr_i (instr_i),
    .halt_o  (halt)
  );

  always_comb begin
    for (int k = 0; k < NCHK; k++) begin
      chk_idx[k] = chk_idx_i[5*k +: 5];
      chk_val[k] = chk_val_i[XLEN*k +: XLEN];
    end
  end

  // Mask as it will read once the slot under test has been recorded, so the
  // final pass verdict can include the last slot in the same edge.
  always_comb begin
    slot_fail   = (shadow_q[chk_k_q] != chk_val[chk_k_q]);
    fail_mask_d = fail_mask_q;
    for (int k = 0; k < NCHK; k++) begin
      if (KW'(k) == chk_k_q) begin
        fail_mask_d[k] = slot_fail;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      chk_k_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_mask_q <= '0;
      // NOTE: the shadow array is reset on purpose: a slot never written by
      // the program must compare as zero, just like the register file.
      for (int k = 0; k < NCHK; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          // Writes to $zero are dropped so an index-0 slot always reads 0.
          for (int k = 0; k < NCHK; k++) begin
            if (rf_we_i && (rf_waddr_i == chk_idx[k]) && (rf_waddr_i != 5'd0)) begin
              shadow_q[k] <= rf_wdata_i;
            end
          end
          if (cnt_q != CW'(TIMEOUT_CYC)) begin
            cnt_q <= cnt_q + CW'(1);
          end
          if (halt) begin
            state_q <= S_CHECK;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_q   <= S_CHECK;
            timeout_q <= 1'b1;
          end
        end

        S_CHECK: begin
          fail_mask_q <= fail_mask_d;
          if (chk_k_q == KW'(NCHK - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= !timeout_q && (fail_mask_d == '0);
          end else begin
            chk_k_q <= chk_k_q + KW'(1);
          end
        end

        default: begin
          state_q <= S_DONE;
        end
      endcase
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign fail_mask_o = fail_mask_q;
  assign cycle_cnt_o = cnt_q;

endmodule
